game_sequencer: RTL
===================

GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, system clock frequency in Hz.
REQ-002 SHALL have parameter TICK_HZ, default 60, game tick rate; TICK_DIV = CLK_HZ/TICK_HZ (integer, >= 2).
REQ-003 SHALL have parameter LIVES, default 3, lives at start (1..15).
REQ-004 SHALL have parameter RESPAWN_TICKS, default 90, frozen ticks after a non-final death (>= 1).
REQ-005 SHALL have parameter SCORE_DIGITS, default 4, BCD score digits (1..8).
REQ-006 SHALL have parameter BOOST_EVERY, default 5, score increments per lava boost pulse; 0 = boost disabled.
REQ-007 SHALL have ports: clk  in  1  system clock; all state on rising edge.
REQ-008 rst  in  1  asynchronous, active-low reset.
REQ-009 in_lava  in  1  player overlaps lava (level).
REQ-010 hit_lava_wall  in  1  lava wall reached player (level).
REQ-011 at_goal_region  in  1  player in goal (level).
REQ-012 jump_landed_pulse  in  1  one-cycle landing event, any cycle.
REQ-013 pause_btn  in  1  pause button, active-high level, already synchronised.
REQ-014 restart  in  1  one-cycle synchronous restart request.
REQ-015 game_tick  out  1  one-cycle tick strobe.
REQ-016 game_state  out  3  0=RUNNING 1=GAME_OVER 2=WIN 3=RESPAWN 4=PAUSED.
REQ-017 freeze  out  1  high whenever game_state != RUNNING.
REQ-018 lives_left  out  4  remaining lives.
REQ-019 score_bcd  out  4*SCORE_DIGITS  BCD score, digit 0 in LSBs.
REQ-020 respawn_pulse  out  1  one cycle at entry to RESPAWN.
REQ-021 lava_boost_pulse  out  1  one cycle per BOOST_EVERY score increments.

Function
REQ-022 Tick counter SHALL count 0..TICK_DIV-1 and wrap; game_tick SHALL be high the cycle after the counter equals TICK_DIV-1; restart SHALL NOT affect the counter.
REQ-023 jump_landed_pulse SHALL set a sticky landing flag; flag cleared on each game_tick cycle; multiple landings between ticks count once.
REQ-024 On a game_tick cycle in RUNNING, priority: death (in_lava|hit_lava_wall) > goal > score update; no score update in a tick where death or goal is taken.
REQ-025 Death with lives_left > 1: lives_left decrements, state -> RESPAWN, respawn counter loads RESPAWN_TICKS, respawn_pulse high one cycle.
REQ-026 Death with lives_left == 1: lives_left -> 0, state -> GAME_OVER.
REQ-027 Goal: state -> WIN; GAME_OVER and WIN hold until restart or reset.
REQ-028 RESPAWN: counter decrements per tick; on tick with counter == 1 state -> RUNNING; deaths and landings ignored in RESPAWN.
REQ-029 Landing flag set at a RUNNING tick: score_bcd += 1 with per-digit decimal carry; all-9s SHALL saturate (no wrap, no boost).
REQ-030 Boost counter counts real increments; on reaching BOOST_EVERY it resets to 0 and lava_boost_pulse is high in the same cycle as the score update.
REQ-031 freeze and game_state SHALL be registered and change in the same cycle.
REQ-032 restart (any state, any cycle) SHALL, next edge: state RUNNING, lives LIVES, score 0, boost counter 0, flag 0, respawn counter 0, pulses 0; restart beats every other event.

Reset
REQ-033 rst low SHALL immediately force: game_tick 0, tick counter 0, game_state RUNNING, freeze 0, lives_left LIVES, score_bcd 0, respawn_pulse 0, lava_boost_pulse 0, all internal counters/flags 0; reset mid-RESPAWN or mid-PAUSED behaves identically.

Configuration
REQ-034 With GAME_PAUSE_EN defined: rising edge of pause_btn (registered previous value) SHALL toggle RUNNING<->PAUSED at the next clock, not tick-aligned; PAUSED ignores deaths, goal, landings (flag still cleared on ticks); pause edges in other states ignored.
REQ-035 Without GAME_PAUSE_EN: pause_btn SHALL be ignored, PAUSED unreachable, no edge-detect register.

Verification (CLK_HZ=100, TICK_HZ=10, LIVES=2, RESPAWN_TICKS=3, SCORE_DIGITS=2, BOOST_EVERY=2)
REQ-036 Release reset, run 35 cycles -> game_tick pulses at cycles 10, 20, 30 after release; exactly 3 pulses.
REQ-037 Landings before 11 ticks -> score_bcd 0x11 after 11th tick; lava_boost_pulse on 2nd,4th..10th increments (5 pulses); three landings within one tick interval -> +1 only.
REQ-038 in_lava at a tick -> lives 1, state 3, respawn_pulse once, freeze 1 for 3 ticks, then state 0; second in_lava at a tick -> lives 0, state 1, held.
REQ-039 in_lava and at_goal_region same tick -> GAME_OVER/RESPAWN path, not WIN; score frozen at 0x99 after further landings.
REQ-040 restart in WIN with score 0x07 -> next cycle state 0, score 0x00, lives 2, freeze 0; rst low mid-RESPAWN -> all outputs at reset values immediately.
REQ-041 With GAME_PAUSE_EN: pause_btn edge in RUNNING -> state 4, freeze 1; in_lava held 5 ticks -> lives unchanged; second edge -> state 0. Without it -> state stays 0.

Source files
------------

// File: rtl/game_sequencer.sv
// game_sequencer: tick generator, lives/respawn/win/game-over state machine and
// saturating BCD score with a periodic lava boost strobe.
// Optional build macro: GAME_PAUSE_EN adds a pause_btn rising-edge toggle
// between RUNNING and PAUSED. Without it pause_btn is ignored.
//
// state        | meaning
// ST_RUNNING   | normal play; deaths, goal and landings evaluated on ticks
// ST_GAME_OVER | last life lost; held until restart or reset
// ST_WIN       | goal reached; held until restart or reset
// ST_RESPAWN   | frozen for RESPAWN_TICKS ticks after a non-final death
// ST_PAUSED    | frozen by the pause button (GAME_PAUSE_EN builds only)

module game_sequencer #(
  parameter int CLK_HZ        = 50000000,
  parameter int TICK_HZ       = 60,
  parameter int LIVES         = 3,
  parameter int RESPAWN_TICKS = 90,
  parameter int SCORE_DIGITS  = 4,
  parameter int BOOST_EVERY   = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_lava,
  input  logic                      hit_lava_wall,
  input  logic                      at_goal_region,
  input  logic                      jump_landed_pulse,
  input  logic                      pause_btn,
  input  logic                      restart,
  output logic                      game_tick,
  output logic [2:0]                game_state,
  output logic                      freeze,
  output logic [3:0]                lives_left,
  output logic [4*SCORE_DIGITS-1:0] score_bcd,
  output logic                      respawn_pulse,
  output logic                      lava_boost_pulse
);

  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int CW       = $clog2(TICK_DIV);
  localparam int RW       = $clog2(RESPAWN_TICKS + 1);
  // +2 keeps the width at least one bit when the boost is disabled
  localparam int BW       = $clog2(BOOST_EVERY + 2);
  localparam int SW       = 4 * SCORE_DIGITS;

  localparam logic [CW-1:0] TICK_LAST  = CW'(TICK_DIV - 1);
  localparam logic [RW-1:0] RESP_LOAD  = RW'(RESPAWN_TICKS);
  localparam logic [3:0]    LIVES_INIT = 4'(LIVES);
  localparam logic [BW-1:0] BOOST_TGT  = BW'(BOOST_EVERY);

  typedef enum logic [2:0] {
    ST_RUNNING   = 3'd0,
    ST_GAME_OVER = 3'd1,
    ST_WIN       = 3'd2,
    ST_RESPAWN   = 3'd3,
    ST_PAUSED    = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] tick_cnt_q;
  logic          land_q, land_d;
  logic          landed;
  logic [RW-1:0] resp_cnt_q, resp_cnt_d;
  logic [BW-1:0] boost_cnt_q, boost_cnt_d;
  logic [3:0]    lives_q, lives_d;
  logic [SW-1:0] score_q, score_d, score_inc;
  logic          score_sat;
  logic          respawn_pulse_d, boost_pulse_d;
  logic          pause_rise;

  // Free-running tick divider; restart deliberately leaves it alone.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt_q <= '0;
      game_tick  <= 1'b0;
    end else begin
      game_tick  <= (tick_cnt_q == TICK_LAST);
      tick_cnt_q <= (tick_cnt_q == TICK_LAST) ? '0 : tick_cnt_q + CW'(1);
    end
  end

`ifdef GAME_PAUSE_EN
  logic pause_prev_q;

  // Previous pause_btn level for rising-edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pause_prev_q <= 1'b0;
    end else begin
      pause_prev_q <= pause_btn;
    end
  end

  assign pause_rise = pause_btn & ~pause_prev_q;
`else
  logic unused_pause;

  assign unused_pause = pause_btn;
  assign pause_rise   = 1'b0;
`endif

  // A landing in the tick cycle itself still counts toward that tick.
  assign landed = land_q | jump_landed_pulse;

  // Decimal +1 across all digits; a carry out of the top digit means all 9s.
  always_comb begin
    score_inc = score_q;
    score_sat = 1'b1;
    for (int i = 0; i < SCORE_DIGITS; i++) begin
      if (score_sat) begin
        if (score_q[4*i +: 4] == 4'd9) begin
          score_inc[4*i +: 4] = 4'd0;
        end else begin
          score_inc[4*i +: 4] = score_q[4*i +: 4] + 4'd1;
          score_sat           = 1'b0;
        end
      end
    end
  end

  // Next-state and datapath decisions; restart outranks pause and tick events.
  always_comb begin
    state_d         = state_q;
    lives_d         = lives_q;
    score_d         = score_q;
    boost_cnt_d     = boost_cnt_q;
    resp_cnt_d      = resp_cnt_q;
    respawn_pulse_d = 1'b0;
    boost_pulse_d   = 1'b0;
    land_d          = game_tick ? 1'b0 : landed;

    if (restart) begin
      state_d     = ST_RUNNING;
      lives_d     = LIVES_INIT;
      score_d     = '0;
      boost_cnt_d = '0;
      resp_cnt_d  = '0;
      land_d      = 1'b0;
    end else if (state_q == ST_RUNNING && pause_rise) begin
      state_d = ST_PAUSED;
    end else if (state_q == ST_PAUSED && pause_rise) begin
      state_d = ST_RUNNING;
    end else if (game_tick) begin
      case (state_q)
        ST_RUNNING: begin
          if (in_lava || hit_lava_wall) begin
            if (lives_q > 4'd1) begin
              lives_d         = lives_q - 4'd1;
              state_d         = ST_RESPAWN;
              resp_cnt_d      = RESP_LOAD;
              respawn_pulse_d = 1'b1;
            end else begin
              lives_d = 4'd0;
              state_d = ST_GAME_OVER;
            end
          end else if (at_goal_region) begin
            state_d = ST_WIN;
          end else if (landed && !score_sat) begin
            score_d = score_inc;
            if (BOOST_EVERY != 0) begin
              if (boost_cnt_q + BW'(1) == BOOST_TGT) begin
                boost_cnt_d   = '0;
                boost_pulse_d = 1'b1;
              end else begin
                boost_cnt_d = boost_cnt_q + BW'(1);
              end
            end
          end
        end
        ST_RESPAWN: begin
          if (resp_cnt_q == RW'(1)) begin
            state_d    = ST_RUNNING;
            resp_cnt_d = '0;
          end else begin
            resp_cnt_d = resp_cnt_q - RW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // State and datapath registers; freeze is registered alongside the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= ST_RUNNING;
      freeze           <= 1'b0;
      lives_q          <= LIVES_INIT;
      score_q          <= '0;
      boost_cnt_q      <= '0;
      resp_cnt_q       <= '0;
      land_q           <= 1'b0;
      respawn_pulse    <= 1'b0;
      lava_boost_pulse <= 1'b0;
    end else begin
      state_q          <= state_d;
      freeze           <= (state_d != ST_RUNNING);
      lives_q          <= lives_d;
      score_q          <= score_d;
      boost_cnt_q      <= boost_cnt_d;
      resp_cnt_q       <= resp_cnt_d;
      land_q           <= land_d;
      respawn_pulse    <= respawn_pulse_d;
      lava_boost_pulse <= boost_pulse_d;
    end
  end

  assign game_state = state_q;
  assign lives_left = lives_q;
  assign score_bcd  = score_q;

endmodule
